// File: rtl/little_responder.sv
// Request/response peer: shift-add multiply of a byte operand plus a running word sum.
// Define LITTLE_RESPONDER_SAT_EN to saturate the running sum instead of wrapping it.
module little_responder #(
  parameter int DATA_W = 8,
  parameter int WORD_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_byte,
  input  logic [WORD_W-1:0]     in_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   out_half,
  output logic [WORD_W-1:0]     out_word,
  output logic                  busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_W-1:0]     r_mcand;
  logic [DATA_W-1:0]     r_mplier;
  logic [2*DATA_W-1:0]   r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic [WORD_W-1:0]     r_sum;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [2*DATA_W-1:0]   r_out_half;
  logic [WORD_W-1:0]     r_out_word;
  logic                  r_busy;

  logic [2*DATA_W-1:0]   w_partial;
  logic [2*DATA_W-1:0]   w_addend;
  logic [2*DATA_W-1:0]   w_acc_next;

  // Running-sum update: wraps by default, clamps at all-ones when saturation is built in.
  function automatic logic [WORD_W-1:0] sum_update(input logic [WORD_W-1:0] a,
                                                   input logic [WORD_W-1:0] b);
    logic [WORD_W:0] full;
    full = {1'b0, a} + {1'b0, b};
`ifdef LITTLE_RESPONDER_SAT_EN
    if (full[WORD_W]) begin
      return {WORD_W{1'b1}};
    end else begin
      return full[WORD_W-1:0];
    end
`else
    return full[WORD_W-1:0];
`endif
  endfunction

  // One shift-add step: shifted multiplicand added when the current multiplier bit is set.
  always_comb begin
    w_partial  = {{DATA_W{1'b0}}, r_mcand} << r_cnt;
    if (r_mplier[r_cnt]) begin
      w_addend = w_partial;
    end else begin
      w_addend = {(2*DATA_W){1'b0}};
    end
    w_acc_next = r_acc + w_addend;
  end

  // Sequencer FSM with all handshake and result outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_mcand     <= {DATA_W{1'b0}};
      r_mplier    <= {DATA_W{1'b0}};
      r_acc       <= {(2*DATA_W){1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_sum       <= {WORD_W{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_half  <= {(2*DATA_W){1'b0}};
      r_out_word  <= {WORD_W{1'b0}};
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand    <= in_byte;
            r_mplier   <= in_word[DATA_W-1:0];
            r_acc      <= {(2*DATA_W){1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_sum      <= sum_update(r_sum, in_word);
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_MUL;
          end else begin
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        S_MUL: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CNT_ONE;
          // The last bit's step is folded straight into the published product.
          if (r_cnt == CNT_LAST) begin
            r_out_half  <= w_acc_next;
            r_out_word  <= r_sum;
            r_out_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_state     <= S_MUL;
          end
        end
        S_RESP: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_half  = r_out_half;
  assign out_word  = r_out_word;
  assign busy      = r_busy;

endmodule

// File: tb/tb_little_responder.sv
// Scoreboard bench for little_responder: stimulus pushes expected responses, a monitor pops them.
module tb_little_responder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_half;
  logic [31:0] out_word;
  logic        busy;

  typedef struct packed {
    logic [15:0] h;
    logic [31:0] w;
  } resp_t;

  resp_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    lat;

  little_responder #(.DATA_W(8), .WORD_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_byte(in_byte), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_half(out_half), .out_word(out_word),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {16'd0, out_half, out_word}, 64'd0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp_half", {48'd0, out_half}, {48'd0, e.h});
        check("resp_word", {32'd0, out_word}, {32'd0, e.w});
      end
    end
  end

  task automatic issue(input logic [7:0] b, input logic [31:0] w,
                       input logic [15:0] eh, input logic [31:0] ew,
                       input bit glitch, output int latency);
    int waited;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 30) begin
      @(posedge clk); #1;
      waited++;
    end
    check("wait_in_ready", {63'd0, in_ready}, 64'd1);
    in_byte  = b;
    in_word  = w;
    in_valid = 1'b1;
    exp_q.push_back('{h: eh, w: ew});
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_byte  = 8'd0;
    in_word  = 32'd0;
    check("busy_in_mul", {63'd0, busy}, 64'd1);
    check("in_ready_in_mul", {63'd0, in_ready}, 64'd0);
    latency = -1;
    for (int k = 1; k <= 20; k++) begin
      if (glitch && (k == 3 || k == 5)) begin
        in_valid = 1'b1;
        in_word  = 32'h0000_1000;
        in_byte  = 8'h55;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_word  = 32'd0;
      in_byte  = 8'd0;
      if (out_valid === 1'b1) begin
        latency = k;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    bit seen;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'd0;
    in_word   = 32'd0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_half", {48'd0, out_half}, 64'd0);
    check("rst_out_word", {32'd0, out_word}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    check("idle_no_resp", {63'd0, seen}, 64'd0);

    // Basic request, out_ready already high: one-cycle pulse after edge 8
    out_ready = 1'b1;
    issue(8'd123, 32'd2, 16'd246, 32'd2, 1'b0, lat);
    check("latency_basic", 64'(lat), 64'd8);
    @(posedge clk); #1;
    check("pulse_one_cycle", {63'd0, out_valid}, 64'd0);
    check("in_ready_after", {63'd0, in_ready}, 64'd1);

    // Max operands, accumulation, in_valid pulses during multiply ignored
    issue(8'hFF, 32'h0000_00FF, 16'hFE01, 32'h0000_0101, 1'b1, lat);
    check("latency_max", 64'(lat), 64'd8);
    @(posedge clk); #1;

    // Backpressure: outputs held for 5 cycles
    out_ready = 1'b0;
    issue(8'd3, 32'd5, 16'd15, 32'h0000_0106, 1'b0, lat);
    check("latency_bp", 64'(lat), 64'd8);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_valid", {63'd0, out_valid}, 64'd1);
      check("bp_half", {48'd0, out_half}, 64'd15);
      check("bp_word", {32'd0, out_word}, 64'h106);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {63'd0, out_valid}, 64'd0);
    check("bp_release_ready", {63'd0, in_ready}, 64'd1);
    check("hold_half", {48'd0, out_half}, 64'd15);

    // Wrap vs saturate from a cleared sum, plus zero-operand latency
    do_reset();
    check("reset_clears_word", {32'd0, out_word}, 64'd0);
    issue(8'd1, 32'hFFFF_FFFF, 16'h00FF, 32'hFFFF_FFFF, 1'b0, lat);
    @(posedge clk); #1;
`ifdef LITTLE_RESPONDER_SAT_EN
    issue(8'd0, 32'd2, 16'd0, 32'hFFFF_FFFF, 1'b0, lat);
`else
    issue(8'd0, 32'd2, 16'd0, 32'h0000_0001, 1'b0, lat);
`endif
    check("latency_zero", 64'(lat), 64'd8);
    @(posedge clk); #1;

    // Reset 3 cycles into the multiply discards the request
    in_byte  = 8'd7;
    in_word  = 32'd9;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    check("midrst_no_resp", {63'd0, seen}, 64'd0);
    issue(8'd2, 32'd3, 16'd6, 32'd3, 1'b0, lat);
    check("latency_post_rst", 64'(lat), 64'd8);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/little_responder.md
Name: little_responder

Overview:
- Responder end of the byte/word request interface that generated FSM harnesses drive. A requester presents an 8-bit operand and a 32-bit word; the block answers with a 16-bit product and a 32-bit running sum.
- Multi-cycle shift-add multiply sequenced by an explicit FSM, with valid/ready handshakes on both sides.
- Instantiated under test harnesses and user modules as the reusable request/response peer.

Parameters:
- DATA_W, 8: request byte width. Product width is 2*DATA_W. Multiply latency is DATA_W cycles.
- WORD_W, 32: request word width and running-sum width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- in_byte  input  DATA_W  multiplicand.
- in_word  input  WORD_W  multiplier source (low DATA_W bits) and sum addend (all bits).
- out_valid  output  1  response present.
- out_ready  input  1  requester accepts the response.
- out_half  output  2*DATA_W  in_byte * in_word[DATA_W-1:0], exact and unsigned.
- out_word  output  WORD_W  running sum of in_word over all accepted requests, including the current one.
- busy  output  1  high in any state other than S_IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - state goes to S_IDLE.
  - out_valid=0, out_half=0, out_word=0, busy=0; internal sum=0, bit counter=0.
  - in_ready=1 once reset is released.
- States, encoded 0/1/2: S_IDLE, S_MUL, S_RESP. Unused encoding 3 returns to S_IDLE on the next edge.
- S_IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, the request is accepted:
    - Latch multiplicand = in_byte and multiplier = in_word[DATA_W-1:0].
    - Clear the product accumulator.
    - Set sum <= sum + in_word, mod 2^WORD_W.
    - Set counter=0 and go to S_MUL.
  - No accept means no state change.
- S_MUL:
  - in_ready=0, and in_valid is ignored (nothing is latched).
  - Each edge: if multiplier bit[counter]=1, add (multiplicand << counter) into the 2*DATA_W accumulator. Then counter++.
  - On the edge processing bit DATA_W-1:
    - out_half <= final product, out_word <= sum.
    - out_valid <= 1, go to S_RESP.
- Latency: accept edge = edge 0. out_valid is first high after edge DATA_W (8 with defaults).
- S_RESP:
  - out_valid=1; out_half and out_word are held stable.
  - On an edge with out_ready=1: out_valid <= 0 and go to S_IDLE. in_ready is high the following cycle.
  - If out_ready is already high when out_valid rises, out_valid is a one-cycle pulse.
  - out_ready while out_valid=0 has no effect.
- Outputs keep their last values after handshake completion until the next response overwrites them.
- Throughput: one request per DATA_W+2 cycles minimum.
- Sum wraps modulo 2^WORD_W unless the optional feature below is compiled in.
- Zero operands: product 0 is still delivered with the full DATA_W latency.
- Reset mid-S_MUL or mid-S_RESP: the transaction is discarded, out_valid drops immediately, and the sum clears. No response is ever issued for the discarded request.

Optional Feature:
- Macro: LITTLE_RESPONDER_SAT_EN.
- Defined: the running-sum update saturates at 2^WORD_W-1. Once saturated, the sum stays there until reset.
- Not defined: the sum wraps modulo 2^WORD_W.
- Product behaviour and latency are identical in both builds.

Test Plan:
- Reset check:
  - Hold reset low and toggle clk.
  - Required: out_valid=0, out_half=0, out_word=0, busy=0.
  - Required: after release, in_ready=1 and no response appears without a request.
- Basic request with out_ready=1:
  - Send in_byte=8'd123, in_word=32'd2.
  - Required: out_valid pulses for exactly 1 cycle, first high after edge 8; out_half=16'd246, out_word=32'd2.
- Maximum operands and accumulation:
  - After the basic request, send in_byte=8'hFF, in_word=32'h000000FF.
  - Required: out_half=16'hFE01, out_word=32'h00000101.
  - Required: in_valid pulses presented during S_MUL are ignored, and out_word shows no extra accumulation.
- Backpressure:
  - Keep out_ready=0 for 5 cycles after out_valid rises.
  - Required: out_valid, out_half and out_word are held stable for all 5 cycles.
  - Required: after out_ready=1 for one edge, out_valid=0 and in_ready=1.
- Wrap vs saturate:
  - Send in_word=32'hFFFFFFFF, then in_word=32'd2.
  - Required: second response out_word=32'h00000001 by default, or 32'hFFFFFFFF with LITTLE_RESPONDER_SAT_EN defined.
- Reset mid-operation:
  - Assert reset 3 cycles into S_MUL, then release.
  - Required: out_valid never rises, busy=0 immediately.
  - Required: the next request in_byte=2, in_word=3 returns out_half=6, out_word=3.
